avalon_queue_bank: RTL and testbench
====================================

Name: avalon_queue_bank

Overview:
Parametrised bank of NUM_Q ingress FIFOs behind one Avalon-MM slave port. Software enqueues bytes per queue by address, reads occupancy and empty/full status, and flushes queues. Each queue exposes a first-word-fall-through valid/ready dequeue port to the downstream scheduler and mux stage. Replaces the fixed three-queue, write-only front end.

Parameters:
NUM_Q, 4, number of queues; 1..8.
DATA_W, 8, queue entry width and writedata width.
DEPTH, 16, entries per queue; power of two, 2..256.
ADDR_W, 4, Avalon address width; must satisfy 2^ADDR_W >= NUM_Q+4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  ADDR_W  register/queue select
writedata  in  DATA_W  enqueue data or flush mask
readdata  out  8  registered status readback
deq_valid  out  NUM_Q  per-queue head valid (queue non-empty)
deq_ready  in  NUM_Q  per-queue pop request
deq_data  out  NUM_Q*DATA_W  per-queue head data; queue q occupies bits [q*DATA_W +: DATA_W]

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Address map. Writes:
  - 0: flush; writedata bit q=1 empties queue q.
  - 1..NUM_Q: enqueue writedata into queue (address-1).
  - All others: ignored.
- Address map. Reads:
  - 0: empty bitmap, zero-extended.
  - 1..NUM_Q: occupancy of queue (address-1), range 0..DEPTH, saturating at 255.
  - NUM_Q+1: full bitmap.
  - NUM_Q+2 and NUM_Q+3: drop counters (optional feature only).
  - Others: 0.
- Read latency is 1 cycle. readdata is registered on a cycle with chipselect&&read and holds its value otherwise.
- Enqueue accepted in the same cycle as chipselect&&write; entry is visible at deq_data/deq_valid the next cycle.
- Full queue:
  - Write is dropped and contents are unchanged.
  - If deq_ready for that queue is high in the same cycle, the pop occurs and the write is accepted; count stays DEPTH.
- Pop occurs when deq_valid[q]&&deq_ready[q]. deq_ready on an empty queue is ignored. Push to an empty queue with deq_ready high: push only; the pop is not performed.
- Simultaneous push and pop on a non-full, non-empty queue: count unchanged, pointers both advance.
- Flush: takes effect at the clock edge and has priority over push and pop in the same cycle; count becomes 0 and deq_valid[q]=0 next cycle. A dropped push during flush is not counted as a drop.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Queues are independent; operations on different queues in the same cycle do not interact.
- Reset values: all counts 0, pointers 0, deq_valid=0, readdata=0, drop counters 0. deq_data is don't-care while deq_valid=0.
- Reset mid-operation empties all queues. Storage RAM is not cleared.

Optional Feature:
- Macro: AVALON_QUEUE_BANK_DROP_CNT_EN.
- When defined:
  - Per-queue 8-bit saturating drop counter, incremented on each rejected enqueue to a full queue.
  - Read at NUM_Q+2 returns the counter of the queue selected by the last write to NUM_Q+2 (writedata low bits).
  - Read at NUM_Q+3 returns the OR-reduced "any drop" flag.
  - Write at NUM_Q+3 clears all counters.
- When undefined: no counters; NUM_Q+2 and NUM_Q+3 read 0 and writes to them are ignored.

Decomposition:
- Package avalon_queue_bank_pkg: address offset constants (ADDR_FLUSH=0, ADDR_Q_BASE=1, relative offsets for full bitmap and drop registers), status-width localparams, and a function computing log2 depth.
- Sub-module queue_fifo, one per queue via generate:
  - Parameters: DATA_W, DEPTH.
  - Ports: push, pop, flush, din, dout, empty, full, count.
  - Implements FWFT and the push/pop/flush priority rules above.

Test Plan:
1. Reset, then write 0xA1, 0xA2 to address 2 -> deq_valid=0010 one cycle later, deq_data[15:8]=0xA1, read address 2 returns 2.
2. Fill queue 0 with 16 writes, then one more with 0xFF -> full bitmap read=0x01, occupancy 16, 0xFF never dequeued; with the feature on, drop counter for queue 0 = 1.
3. Full queue 0, push 0x55 with deq_ready[0]=1 same cycle -> pop accepted, push accepted, occupancy stays 16, 0x55 emerges 16th.
4. Queues 1 and 3 non-empty, write 0x0A to address 0 while also writing to address 4 -> empty bitmap=0x0F next cycle, queue 3 push discarded, no drop counted.
5. Push 20 and pop 20 interleaved on queue 2 across a pointer wrap -> data order preserved, final occupancy 0.
6. Assert reset mid-burst with 5 entries queued -> deq_valid=0, all occupancies 0, readdata=0 on the cycle after reset.

Source files
------------

// File: rtl/avalon_queue_bank_pkg.sv
// Shared address offsets, status widths and sizing helper for avalon_queue_bank.
package avalon_queue_bank_pkg;

  localparam int ADDR_FLUSH   = 0;
  localparam int ADDR_Q_BASE  = 1;
  // Offsets past the last queue address (NUM_Q + offset)
  localparam int OFS_FULL     = 1;
  localparam int OFS_DROP_SEL = 2;
  localparam int OFS_DROP_ANY = 3;

  localparam int STAT_W = 8;
  localparam int DROP_W = 8;

  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < depth) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/avalon_queue_bank_queue_fifo.sv
// First-word-fall-through FIFO; flush beats push/pop, a full queue takes a push only if it pops.
module queue_fifo
  import avalon_queue_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [DATA_W-1:0]           din_i,
  output logic [DATA_W-1:0]           dout_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [clog2_depth(DEPTH):0] count_o
);

  localparam int PTR_W = clog2_depth(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  // Pop on empty is ignored, so push+ready on an empty queue is push-only.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/avalon_queue_bank.sv
// Avalon-MM bank of NUM_Q FWFT ingress queues with status readback.
// Define AVALON_QUEUE_BANK_DROP_CNT_EN to add per-queue saturating drop counters.
module avalon_queue_bank
  import avalon_queue_bank_pkg::*;
#(
  parameter int NUM_Q  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       writedata,
  output logic [7:0]              readdata,
  output logic [NUM_Q-1:0]        deq_valid,
  input  logic [NUM_Q-1:0]        deq_ready,
  output logic [NUM_Q*DATA_W-1:0] deq_data
);

  localparam int CNT_W = clog2_depth(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_FLUSH = ADDR_W'(ADDR_FLUSH);
  localparam logic [ADDR_W-1:0] A_FULL  = ADDR_W'(NUM_Q + OFS_FULL);

  logic              wr_en, rd_en;
  logic [NUM_Q-1:0]  push, flush, empty, full;
  logic [CNT_W-1:0]  count [NUM_Q];
  logic [DATA_W-1:0] dout  [NUM_Q];
  logic [STAT_W-1:0] occ   [NUM_Q];
  logic [STAT_W-1:0] rd_val, readdata_q, readdata_d;

  assign wr_en = chipselect && write;
  assign rd_en = chipselect && read;

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    assign push[q] = wr_en && (address == ADDR_W'(ADDR_Q_BASE + q));
    if (q < DATA_W) begin : g_fl
      assign flush[q] = wr_en && (address == A_FLUSH) && writedata[q];
    end else begin : g_nofl
      assign flush[q] = 1'b0;
    end

    queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push[q]),
      .pop_i   (deq_ready[q]),
      .flush_i (flush[q]),
      .din_i   (writedata),
      .dout_o  (dout[q]),
      .empty_o (empty[q]),
      .full_o  (full[q]),
      .count_o (count[q])
    );

    assign deq_data[q*DATA_W +: DATA_W] = dout[q];

    // DEPTH=256 needs a 9-bit count; readback clips at 255.
    if (CNT_W > STAT_W) begin : g_sat
      assign occ[q] = (count[q] > CNT_W'(255)) ? 8'hFF : count[q][STAT_W-1:0];
    end else begin : g_ext
      assign occ[q] = STAT_W'(count[q]);
    end
  end

  assign deq_valid = ~empty;

`ifdef AVALON_QUEUE_BANK_DROP_CNT_EN
  localparam logic [ADDR_W-1:0] A_DSEL = ADDR_W'(NUM_Q + OFS_DROP_SEL);
  localparam logic [ADDR_W-1:0] A_DANY = ADDR_W'(NUM_Q + OFS_DROP_ANY);

  logic [DROP_W-1:0] drop_cnt_q [NUM_Q];
  logic [2:0]        sel_q, sel_wd;
  logic [NUM_Q-1:0]  drop, cnt_nz;
  logic [STAT_W-1:0] sel_val;

  if (DATA_W >= 3) begin : g_sw
    assign sel_wd = writedata[2:0];
  end else begin : g_sn
    assign sel_wd = 3'(writedata);
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_drop
    // A push lost to a flush is not a drop.
    assign drop[q]   = push[q] && full[q] && !deq_ready[q] && !flush[q];
    assign cnt_nz[q] = (drop_cnt_q[q] != '0);
  end

  always_comb begin
    sel_val = '0;
    for (int q = 0; q < NUM_Q; q++)
      if (sel_q == 3'(q)) sel_val = drop_cnt_q[q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      for (int q = 0; q < NUM_Q; q++) drop_cnt_q[q] <= '0;
    end else begin
      if (wr_en && address == A_DSEL) sel_q <= sel_wd;
      for (int q = 0; q < NUM_Q; q++) begin
        if (wr_en && address == A_DANY)
          drop_cnt_q[q] <= '0;
        else if (drop[q] && drop_cnt_q[q] != '1)
          drop_cnt_q[q] <= drop_cnt_q[q] + DROP_W'(1);
      end
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    if (address == A_FLUSH)     rd_val = STAT_W'(empty);
    else if (address == A_FULL) rd_val = STAT_W'(full);
    else begin
      for (int q = 0; q < NUM_Q; q++)
        if (address == ADDR_W'(ADDR_Q_BASE + q)) rd_val = occ[q];
    end
`ifdef AVALON_QUEUE_BANK_DROP_CNT_EN
    if (address == A_DSEL) rd_val = sel_val;
    if (address == A_DANY) rd_val = {7'b0, |cnt_nz};
`endif
  end

  assign readdata_d = rd_en ? rd_val : readdata_q;

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_avalon_queue_bank.sv
// Random and directed checks of avalon_queue_bank against a queue-based reference model.
module tb_avalon_queue_bank;
  localparam int NQ = 4, DW = 8, DEPTH = 16, AW = 4;

  logic          clk, reset, chipselect, write, read;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic [7:0]    readdata;
  logic [NQ-1:0] deq_valid, deq_ready;
  logic [NQ*DW-1:0] deq_data;

  avalon_queue_bank #(.NUM_Q(NQ), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit chk_en = 0;

  logic [7:0] mq [NQ][$];
  int         drops [NQ];
  int         sel;
  logic [7:0] exp_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input int a);
    logic [7:0] v;
    v = 0;
    if (a == 0) begin
      for (int q = 0; q < NQ; q++) v[q] = (mq[q].size() == 0);
    end else if (a >= 1 && a <= NQ) v = 8'(mq[a-1].size());
    else if (a == NQ + 1) begin
      for (int q = 0; q < NQ; q++) v[q] = (mq[q].size() == DEPTH);
    end
`ifdef AVALON_QUEUE_BANK_DROP_CNT_EN
    else if (a == NQ + 2) v = (sel < NQ) ? 8'(drops[sel]) : 8'h0;
    else if (a == NQ + 3) begin
      for (int q = 0; q < NQ; q++) if (drops[q] != 0) v = 8'h1;
    end
`endif
    return v;
  endfunction

  // Reference model: advances on every clock edge from the pre-edge state.
  always @(posedge clk) begin
    if (reset) begin
      for (int q = 0; q < NQ; q++) begin mq[q].delete(); drops[q] = 0; end
      exp_rd = 0;
      sel = 0;
    end else begin
      bit wr;
      wr = chipselect && write;
      if (chipselect && read) exp_rd = model_read(int'(address));
      for (int q = 0; q < NQ; q++) begin
        bit fl, pu, po, was_full;
        fl = wr && address == 0 && writedata[q];
        pu = wr && int'(address) == q + 1;
        po = deq_ready[q] && mq[q].size() > 0;
        was_full = mq[q].size() == DEPTH;
        if (fl) mq[q].delete();
        else begin
          if (po) void'(mq[q].pop_front());
          if (pu) begin
            if (!was_full || po) mq[q].push_back(writedata);
            else if (drops[q] < 255) drops[q]++;
          end
        end
      end
      if (wr && int'(address) == NQ + 2) sel = int'(writedata[2:0]);
      if (wr && int'(address) == NQ + 3) for (int q = 0; q < NQ; q++) drops[q] = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int q = 0; q < NQ; q++) begin
        chk($sformatf("deq_valid[%0d]", q), 32'(deq_valid[q]), 32'(mq[q].size() > 0));
        if (mq[q].size() > 0)
          chk($sformatf("deq_data[%0d]", q), 32'(deq_data[q*DW +: DW]), 32'(mq[q][0]));
      end
      chk("readdata", 32'(readdata), 32'(exp_rd));
    end
  end

  task automatic step();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    chipselect = 1; write = 1; address = AW'(a); writedata = d;
    step();
    chipselect = 0; write = 0;
  endtask

  task automatic rd(input int a);
    chipselect = 1; read = 1; address = AW'(a);
    step();
    chipselect = 0; read = 0;
  endtask

  initial begin
    logic [7:0] e;
    reset = 1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0; deq_ready = 0;
    step();
    chk_en = 1;
    step();
    reset = 0;
    chk("reset deq_valid", 32'(deq_valid), 32'h0);
    chk("reset readdata", 32'(readdata), 32'h0);

    // Plan 1
    wr(2, 8'hA1);
    wr(2, 8'hA2);
    chk("t1 deq_valid", 32'(deq_valid), 32'h2);
    chk("t1 head q1", 32'(deq_data[15:8]), 32'hA1);
    rd(2);
    chk("t1 occ q1", 32'(readdata), 32'd2);

    // Plan 2
    for (int i = 0; i < DEPTH; i++) wr(1, 8'(i));
    wr(1, 8'hFF);
    rd(NQ + 1);
    chk("t2 full map", 32'(readdata), 32'h1);
    rd(1);
    chk("t2 occ q0", 32'(readdata), 32'd16);
`ifdef AVALON_QUEUE_BANK_DROP_CNT_EN
    wr(NQ + 2, 8'h0);
    rd(NQ + 2);
    chk("t2 drop q0", 32'(readdata), 32'd1);
    rd(NQ + 3);
    chk("t2 drop any", 32'(readdata), 32'd1);
    wr(NQ + 3, 8'h0);
    rd(NQ + 3);
    chk("t2 drop clear", 32'(readdata), 32'd0);
`endif

    // Plan 3
    deq_ready[0] = 1;
    wr(1, 8'h55);
    deq_ready[0] = 0;
    rd(1);
    chk("t3 occ q0", 32'(readdata), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      e = (i < DEPTH - 1) ? 8'(i + 1) : 8'h55;
      chk("t3 drain order", 32'(deq_data[7:0]), 32'(e));
      deq_ready[0] = 1;
      step();
    end
    deq_ready[0] = 0;
    chk("t3 q0 empty", 32'(deq_valid[0]), 32'h0);

    // Plan 4
    wr(4, 8'h33);
    wr(0, 8'h0A);
    rd(0);
    chk("t4 empty map", 32'(readdata), 32'h0F);

    // Plan 5
    e = 8'hC0;
    for (int i = 0; i < 20; i++) begin
      deq_ready[2] = 1;
      if (deq_valid[2]) begin
        chk("t5 order", 32'(deq_data[23:16]), 32'(e));
        e++;
      end
      wr(3, 8'(8'hC0 + i));
    end
    chk("t5 last", 32'(deq_data[23:16]), 32'hD3);
    step();
    deq_ready[2] = 0;
    rd(3);
    chk("t5 occ q2", 32'(readdata), 32'd0);

    // Plan 6
    for (int i = 0; i < 5; i++) wr(2, 8'(i));
    rd(2);
    chipselect = 1; write = 1; address = 2; writedata = 8'h77; reset = 1;
    step();
    reset = 0; chipselect = 0; write = 0;
    chk("t6 deq_valid", 32'(deq_valid), 32'h0);
    chk("t6 readdata", 32'(readdata), 32'h0);
    for (int a = 1; a <= NQ; a++) begin
      rd(a);
      chk("t6 occ", 32'(readdata), 32'h0);
    end

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write      = $urandom_range(0, 1);
      read       = $urandom_range(0, 1);
      address    = AW'($urandom_range(0, 7));
      if (address == 0 && $urandom_range(0, 7) != 0) address = AW'($urandom_range(1, NQ));
      writedata  = 8'($urandom);
      deq_ready  = NQ'($urandom) & NQ'($urandom);
      step();
    end
    chipselect = 0; write = 0; read = 0; deq_ready = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
